// File: rtl/ghost_turn_server.sv
`timescale 1ns/1ps
// Purpose: arbitrates turn requests from four ghosts and returns a new direction (chase Pac-Man or LFSR-random).
// Latency: request sampled at edge N -> turn_ack high after edge N+3; at least 5 cycles between successive grants.
// Backpressure: 4-phase req/ack; ack holds until the served request drops, other requests wait (level-sensitive).
//
// Ports:
//   clkdiv, rst            block clock, synchronous active-low reset
//   pac_x, pac_y           Pac-Man position
//   ghost_x/_y/_dir        per-ghost position and current (blocked) direction, packed per ghost
//   turn_req               per-ghost level request
//   turn_ack               one-hot acknowledge to the served ghost
//   turn_dir               granted direction (00 up, 01 down, 10 left, 11 right), valid with turn_ack
//   serve_idx              index of the ghost being served
//   busy                   high whenever the server is not idle
module ghost_turn_server #(
    parameter int          NUM_GHOSTS   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CHASE_THRESH = 8
) (
    input  logic                      clkdiv,
    input  logic                      rst,
    input  logic [9:0]                pac_x,
    input  logic [8:0]                pac_y,
    input  logic [NUM_GHOSTS*10-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*9-1:0]   ghost_y,
    input  logic [NUM_GHOSTS*2-1:0]   ghost_dir,
    input  logic [NUM_GHOSTS-1:0]     turn_req,
    output logic [NUM_GHOSTS-1:0]     turn_ack,
    output logic [1:0]                turn_dir,
    output logic [1:0]                serve_idx,
    output logic                      busy
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [4:0]  THRESH   = 5'(CHASE_THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_DECIDE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_nxt;
    logic [1:0]         rr_ptr_q;
    logic [1:0]         lat_dir_q;
    logic signed [10:0] dx_q;
    logic signed [9:0]  dy_q;
    logic [1:0]         res_q;

    // Round-robin pick
    logic               pick_vld;
    logic [1:0]         pick_idx;
    logic [1:0]         pick_cand;

    // Selected ghost view
    logic [9:0]         sel_gx;
    logic [8:0]         sel_gy;
    logic [1:0]         sel_dir;
    logic               req_held;
    logic signed [10:0] dx_now;
    logic signed [9:0]  dy_now;

    // Decision datapath
    logic [10:0]        abs_dx;
    logic [9:0]         abs_dy;
    logic               x_primary;
    logic [1:0]         x_cand, y_cand;
    logic               x_ok, y_ok;
    logic               chase_mode;
    logic [1:0]         rnd_dir;
    logic [1:0]         decide_dir;

    // Galois, right shift: the shifted-out bit folds the tap mask back in.
    assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // First requester strictly after the last one served, wrapping mod 4.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = rr_ptr_q;
        pick_cand = rr_ptr_q;
        for (int i = 1; i <= 4; i++) begin
            pick_cand = rr_ptr_q + 2'(i);
            if (!pick_vld && turn_req[pick_cand]) begin
                pick_vld = 1'b1;
                pick_idx = pick_cand;
            end
        end
    end

    always_comb begin
        sel_gx  = ghost_x[9:0];
        sel_gy  = ghost_y[8:0];
        sel_dir = ghost_dir[1:0];
        case (serve_idx)
            2'd1: begin
                sel_gx  = ghost_x[19:10];
                sel_gy  = ghost_y[17:9];
                sel_dir = ghost_dir[3:2];
            end
            2'd2: begin
                sel_gx  = ghost_x[29:20];
                sel_gy  = ghost_y[26:18];
                sel_dir = ghost_dir[5:4];
            end
            2'd3: begin
                sel_gx  = ghost_x[39:30];
                sel_gy  = ghost_y[35:27];
                sel_dir = ghost_dir[7:6];
            end
            default: begin
                sel_gx  = ghost_x[9:0];
                sel_gy  = ghost_y[8:0];
                sel_dir = ghost_dir[1:0];
            end
        endcase
    end

    assign req_held = turn_req[serve_idx];

    // Zero-extended operands: 10/9-bit coordinates always fit 11/10-bit signed deltas.
    assign dx_now = {1'b0, pac_x} - {1'b0, sel_gx};
    assign dy_now = {1'b0, pac_y} - {1'b0, sel_gy};

    assign abs_dx = dx_q[10] ? (~dx_q + 11'd1) : dx_q;
    assign abs_dy = dy_q[9]  ? (~dy_q + 10'd1) : dy_q;

    // X wins ties on the primary axis.
    assign x_primary = (abs_dx >= {1'b0, abs_dy});

    assign x_cand = dx_q[10] ? 2'b10 : 2'b11;
    assign y_cand = dy_q[9]  ? 2'b00 : 2'b01;
    assign x_ok   = (dx_q != 11'sd0) && (x_cand != lat_dir_q);
    assign y_ok   = (dy_q != 10'sd0) && (y_cand != lat_dir_q);

    assign chase_mode = ({1'b0, lfsr_q[3:0]} < THRESH);

    // Random pick steps past the blocked direction so the result never repeats it.
    assign rnd_dir = (lfsr_q[5:4] == lat_dir_q) ? (lfsr_q[5:4] + 2'd1) : lfsr_q[5:4];

    always_comb begin
        decide_dir = rnd_dir;
        if (chase_mode) begin
            if (x_primary) begin
                if (x_ok)      decide_dir = x_cand;
                else if (y_ok) decide_dir = y_cand;
            end else begin
                if (y_ok)      decide_dir = y_cand;
                else if (x_ok) decide_dir = x_cand;
            end
        end
    end

    // Next-state: any drop of the served request before a grant abandons it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pick_vld) state_d = S_LATCH;
            S_LATCH:  state_d = req_held ? S_DECIDE : S_IDLE;
            S_DECIDE: state_d = req_held ? S_ACK    : S_IDLE;
            S_ACK:    if (!req_held) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkdiv) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            rr_ptr_q  <= 2'd3;
            serve_idx <= 2'd0;
            lat_dir_q <= 2'd0;
            dx_q      <= 11'sd0;
            dy_q      <= 10'sd0;
            res_q     <= 2'd0;
            turn_ack  <= '0;
            turn_dir  <= 2'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_nxt;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        rr_ptr_q  <= pick_idx;
                        serve_idx <= pick_idx;
                    end
                end
                S_LATCH: begin
                    lat_dir_q <= sel_dir;
                    dx_q      <= dx_now;
                    dy_q      <= dy_now;
                end
                S_DECIDE: begin
                    res_q <= decide_dir;
                end
                S_ACK: begin
                    // turn_dir is only updated alongside a grant, so it keeps
                    // the last granted value once the ack drops.
                    if (req_held) begin
                        turn_ack <= NUM_GHOSTS'(1) << serve_idx;
                        turn_dir <= res_q;
                    end else begin
                        turn_ack <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule
